// File: rtl/uart_rx_core_pkg.sv
// rtl/uart_rx_core_pkg.sv - shared UART codes: parity modes, FSM encodings, counter width helper
package uart_rx_core_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;
   localparam logic [2:0] ST_LOAD   = 3'd5;

   typedef struct packed {
      logic parity;
      logic frame;
   } rx_err_t;

   function automatic int os_cnt_w(input int osr);
      return $clog2(osr);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with parameterised reset value
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver with majority vote and valid/ready holding register
module uart_rx_core
   import uart_rx_core_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OSR       = 16,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_en,
   input  logic              rx_in,
   input  logic              os_tick,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = 4;
   localparam int OS_W  = os_cnt_w(OSR);

   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OSR - 1);
   localparam logic [OS_W-1:0]  OS_SAMP_LO = OS_W'(OSR / 2 - 1);
   localparam logic [OS_W-1:0]  OS_SAMP_HI = OS_W'(OSR / 2 + 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

   logic              rx_s;
   logic              rx_prev_q;
   logic              fall;
   logic              period_end;
   logic              vote;

   logic [2:0]        state_q,   state_d;
   logic [OS_W-1:0]   os_cnt_q,  os_cnt_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]        samp_q,    samp_d;
   logic [DATA_W-1:0] shift_q,   shift_d;
   rx_err_t           err_q,     err_d;

   logic [DATA_W-1:0] rx_data_q,  rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   rx_err_t           out_err_q,  out_err_d;
   logic              overrun_q,  overrun_d;
   logic              load_ok;
   logic              handshake;

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk   (clk),
      .rst_n (rst),
      .d_i   (rx_in),
      .q_o   (rx_s)
   );

   // Re-arming needs a real 1->0 edge, so a held-low break cannot restart frames.
   assign fall       = rx_prev_q & ~rx_s;
   assign period_end = os_tick & (os_cnt_q == OS_LAST);
   assign vote       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

   always_comb begin
      state_d   = state_q;
      os_cnt_d  = os_cnt_q;
      bit_cnt_d = bit_cnt_q;
      samp_d    = samp_q;
      shift_d   = shift_q;
      err_d     = err_q;

      if (state_q != ST_IDLE && state_q != ST_LOAD && os_tick) begin
         os_cnt_d = period_end ? '0 : os_cnt_q + OS_W'(1);
         if (os_cnt_q >= OS_SAMP_LO && os_cnt_q <= OS_SAMP_HI) begin
            samp_d = {samp_q[1:0], rx_s};
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d  = ST_START;
               os_cnt_d = '0;
               err_d    = '0;
            end
         end
         ST_START: begin
            if (period_end) begin
               if (vote) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         ST_DATA: begin
            if (period_end) begin
               shift_d = {vote, shift_q[DATA_W-1:1]};
               if (bit_cnt_q == DATA_LAST) begin
                  state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (period_end) begin
               err_d.parity = ((vote ^ (^shift_q)) != (PARITY == PAR_ODD));
               state_d      = ST_STOP;
            end
         end
         ST_STOP: begin
            if (period_end) begin
               if (!vote) begin
                  err_d.frame = 1'b1;
               end
               if (bit_cnt_q == STOP_LAST) begin
                  state_d = ST_LOAD;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_LOAD: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (!rx_en) begin
         state_d = ST_IDLE;
      end
   end

   // Output holding register: a completed frame only lands when the slot is free or draining now.
   assign handshake = rx_valid_q & rx_ready;
   assign load_ok   = ~rx_valid_q | rx_ready;

   always_comb begin
      rx_data_d  = rx_data_q;
      out_err_d  = out_err_q;
      rx_valid_d = rx_valid_q & ~rx_ready;
      overrun_d  = overrun_q;

      if (handshake) begin
         overrun_d = 1'b0;
      end
      if (state_q == ST_LOAD) begin
         if (load_ok) begin
            rx_data_d  = shift_q;
            out_err_d  = err_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_prev_q  <= 1'b1;
         state_q    <= ST_IDLE;
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         samp_q     <= '0;
         shift_q    <= '0;
         err_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         out_err_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         rx_prev_q  <= rx_s;
         state_q    <= state_d;
         os_cnt_q   <= os_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         err_q      <= err_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         out_err_q  <= out_err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = out_err_q.parity;
   assign frame_err  = out_err_q.frame;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed scoreboard bench for uart_rx_core in three configurations
module tb_uart_rx_core;

   localparam int OSR = 16;

   typedef struct packed {
      logic       pe;
      logic       fe;
      logic [8:0] data;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       os_tick;
   logic [2:0] rx_line;
   logic [2:0] rx_en;
   logic       rdy0;

   logic [7:0] data0, data1;
   logic [4:0] data2;
   logic       valid0, valid1, valid2;
   logic       pe0, pe1, pe2;
   logic       fe0, fe1, fe2;
   logic       ovr0, ovr1, ovr2;
   logic       busy0, busy1, busy2;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t q0[$], q1[$], q2[$];
   exp_t e0, e1, e2;

   uart_rx_core #(.DATA_W(8), .OSR(OSR), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .rx_en(rx_en[0]), .rx_in(rx_line[0]), .os_tick(os_tick),
      .rx_data(data0), .rx_valid(valid0), .rx_ready(rdy0), .parity_err(pe0),
      .frame_err(fe0), .overrun(ovr0), .busy(busy0));

   uart_rx_core #(.DATA_W(8), .OSR(OSR), .PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .rx_en(rx_en[1]), .rx_in(rx_line[1]), .os_tick(os_tick),
      .rx_data(data1), .rx_valid(valid1), .rx_ready(1'b1), .parity_err(pe1),
      .frame_err(fe1), .overrun(ovr1), .busy(busy1));

   uart_rx_core #(.DATA_W(5), .OSR(OSR), .PARITY(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .rx_en(rx_en[2]), .rx_in(rx_line[2]), .os_tick(os_tick),
      .rx_data(data2), .rx_valid(valid2), .rx_ready(1'b1), .parity_err(pe2),
      .frame_err(fe2), .overrun(ovr2), .busy(busy2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One os_tick every fourth clock.
   initial begin
      os_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 os_tick = 1'b1;
         @(posedge clk);
         #1 os_tick = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic pe, input logic fe, input logic [8:0] d);
      exp_t r;
      r.pe   = pe;
      r.fe   = fe;
      r.data = d;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (os_tick !== 1'b1);
      #2;
   endtask

   task automatic ticks(input int n);
      repeat (n) wait_tick();
   endtask

   task automatic send_frame(input logic [1:0] sel, input logic [8:0] data, input int nbits,
                             input int par, input logic [1:0] stops, input int nstop);
      wait_tick();
      rx_line[sel] = 1'b0;
      ticks(OSR);
      for (int i = 0; i < nbits; i++) begin
         rx_line[sel] = data[i];
         ticks(OSR);
      end
      if (par >= 0) begin
         rx_line[sel] = par[0];
         ticks(OSR);
      end
      for (int i = 0; i < nstop; i++) begin
         rx_line[sel] = stops[i];
         ticks(OSR);
      end
      rx_line[sel] = 1'b1;
   endtask

   always @(negedge clk) begin
      if (valid0 && rdy0) begin
         check("dut0 frame expected", 32'(q0.size() != 0), 32'd1);
         if (q0.size() != 0) begin
            e0 = q0.pop_front();
            check("dut0 frame {pe,fe,data}", 32'({pe0, fe0, data0}), 32'({e0.pe, e0.fe, e0.data[7:0]}));
         end
      end
      if (valid1) begin
         check("dut1 frame expected", 32'(q1.size() != 0), 32'd1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            check("dut1 frame {pe,fe,data}", 32'({pe1, fe1, data1}), 32'({e1.pe, e1.fe, e1.data[7:0]}));
         end
      end
      if (valid2) begin
         check("dut2 frame expected", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            check("dut2 frame {pe,fe,data}", 32'({pe2, fe2, data2}), 32'({e2.pe, e2.fe, e2.data[4:0]}));
         end
      end
   end

   initial begin
      rst     = 1'b0;
      rx_line = 3'b111;
      rx_en   = 3'b111;
      rdy0    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset rx_valid", 32'(valid0), 32'd0);
      check("reset busy", 32'(busy0), 32'd0);
      check("reset overrun", 32'(ovr0), 32'd0);
      check("reset errs", 32'({pe0, fe0}), 32'd0);
      check("reset rx_data", 32'(data0), 32'd0);
      rst = 1'b1;
      ticks(4);
      check("idle after reset busy", 32'(busy0), 32'd0);

      q0.push_back(mk(1'b0, 1'b0, 9'h0A5));
      send_frame(2'd0, 9'h0A5, 8, -1, 2'b11, 1);
      ticks(4);
      check("A5 drained", 32'(q0.size()), 32'd0);
      check("A5 valid single pulse", 32'(valid0), 32'd0);

      q1.push_back(mk(1'b1, 1'b0, 9'h03C));
      send_frame(2'd1, 9'h03C, 8, 1, 2'b11, 1);
      q1.push_back(mk(1'b0, 1'b0, 9'h03C));
      send_frame(2'd1, 9'h03C, 8, 0, 2'b11, 1);
      q1.push_back(mk(1'b0, 1'b0, 9'h007));
      send_frame(2'd1, 9'h007, 8, 1, 2'b11, 1);
      ticks(4);
      check("parity frames drained", 32'(q1.size()), 32'd0);

      q0.push_back(mk(1'b0, 1'b1, 9'h055));
      send_frame(2'd0, 9'h055, 8, -1, 2'b00, 1);
      ticks(OSR);
      q0.push_back(mk(1'b0, 1'b1, 9'h000));
      wait_tick();
      rx_line[0] = 1'b0;
      ticks(20 * OSR);
      check("break yields one frame", 32'(q0.size()), 32'd0);
      check("break holds idle", 32'(busy0), 32'd0);
      rx_line[0] = 1'b1;
      ticks(2 * OSR);
      check("after break idle", 32'(busy0), 32'd0);

      wait_tick();
      rx_line[0] = 1'b0;
      ticks(4);
      rx_line[0] = 1'b1;
      #1;
      check("glitch enters start", 32'(busy0), 32'd1);
      ticks(20);
      check("glitch false start busy", 32'(busy0), 32'd0);
      check("glitch no rx_valid", 32'(valid0), 32'd0);

      rdy0 = 1'b0;
      q0.push_back(mk(1'b0, 1'b0, 9'h011));
      send_frame(2'd0, 9'h011, 8, -1, 2'b11, 1);
      send_frame(2'd0, 9'h022, 8, -1, 2'b11, 1);
      ticks(4);
      check("overrun valid held", 32'(valid0), 32'd1);
      check("overrun data kept", 32'(data0), 32'h11);
      check("overrun flag", 32'(ovr0), 32'd1);
      @(posedge clk);
      #1 rdy0 = 1'b1;
      @(posedge clk);
      #1 rdy0 = 1'b0;
      check("overrun valid cleared", 32'(valid0), 32'd0);
      check("overrun flag cleared", 32'(ovr0), 32'd0);
      rdy0 = 1'b1;

      fork
         send_frame(2'd0, 9'h0F0, 8, -1, 2'b11, 1);
         begin
            ticks(1 + 5 * OSR + 8);
            check("rx_en mid-frame busy", 32'(busy0), 32'd1);
            rx_en[0] = 1'b0;
            @(posedge clk);
            #1;
            check("rx_en abort idle", 32'(busy0), 32'd0);
         end
      join
      rx_en[0] = 1'b1;

      fork
         send_frame(2'd0, 9'h0F0, 8, -1, 2'b11, 1);
         begin
            ticks(1 + 5 * OSR + 8);
            check("rst mid-frame busy", 32'(busy0), 32'd1);
            rst = 1'b0;
            #1;
            check("rst abort idle", 32'(busy0), 32'd0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
         end
      join

      q0.push_back(mk(1'b0, 1'b0, 9'h00F));
      send_frame(2'd0, 9'h00F, 8, -1, 2'b11, 1);
      ticks(4);
      check("0F after aborts drained", 32'(q0.size()), 32'd0);

      q2.push_back(mk(1'b0, 1'b0, 9'h015));
      send_frame(2'd2, 9'h015, 5, -1, 2'b11, 2);
      q2.push_back(mk(1'b0, 1'b1, 9'h015));
      send_frame(2'd2, 9'h015, 5, -1, 2'b01, 2);
      ticks(4);
      check("dut2 frames drained", 32'(q2.size()), 32'd0);

      check("final q0 empty", 32'(q0.size()), 32'd0);
      check("final q1 empty", 32'(q1.size()), 32'd0);
      check("final valids low", 32'({valid0, valid1, valid2}), 32'd0);
      check("final overruns low", 32'({ovr0, ovr1, ovr2}), 32'd0);
      check("final busy low", 32'({busy0, busy1, busy2}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
